// File: rtl/cache_def_pkg.sv
// cache_def_pkg
//   Shared definitions for the set-associative cache controller slice:
//   controller state encoding, per-line metadata record, and helpers that
//   derive the address-split widths from the block parameters.
package cache_def_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        COMPARE    = 2'd1,
        WRITE_BACK = 2'd2,
        ALLOCATE   = 2'd3
    } cache_state_t;

    // Widest tag the metadata record can carry; narrower tags are zero-extended.
    localparam int TAG_MAX = 32;

    typedef struct packed {
        logic               valid;
        logic               dirty;
        logic [TAG_MAX-1:0] tag;
    } line_meta_t;

    function automatic int off_w(input int words);
        return $clog2(words);
    endfunction

    function automatic int idx_w(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_w(input int aw, input int sets, input int words);
        return aw - $clog2(sets) - $clog2(words);
    endfunction

    // Way indices keep at least one bit so a direct-mapped build still has a signal.
    function automatic int way_w(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

endpackage

// File: rtl/cache_set_array.sv
// cache_set_array
//   WAYS x SETS tag/valid/dirty/data storage. Combinational read, synchronous
//   write. Only valid and dirty bits are reset; tags and data are don't-care.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   idx_i         set index for lookup, readout and write
//   tag_i         tag compared against every way of the set
//   hit_o         per-way hit vector (valid and tag match)
//   valid_o       per-way valid bits of the indexed set
//   dirty_o       per-way dirty bits of the indexed set
//   sel_way_i     way whose line and tag are read out
//   sel_line_o    line data of the selected way
//   sel_tag_o     stored tag of the selected way
//   wr_en_i       write the selected set/way (marks it valid)
//   wr_way_i      way to write
//   wr_tag_i      tag to store
//   wr_dirty_i    dirty bit to store
//   wr_line_i     line data to store
module cache_set_array
    import cache_def_pkg::*;
#(
    parameter int WAYS  = 2,
    parameter int SETS  = 8,
    parameter int WORDS = 4,
    parameter int DW    = 16,
    parameter int AW    = 16
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [idx_w(SETS)-1:0]                idx_i,
    input  logic [tag_w(AW, SETS, WORDS)-1:0]     tag_i,
    output logic [WAYS-1:0]                       hit_o,
    output logic [WAYS-1:0]                       valid_o,
    output logic [WAYS-1:0]                       dirty_o,
    input  logic [way_w(WAYS)-1:0]                sel_way_i,
    output logic [WORDS*DW-1:0]                   sel_line_o,
    output logic [tag_w(AW, SETS, WORDS)-1:0]     sel_tag_o,
    input  logic                                  wr_en_i,
    input  logic [way_w(WAYS)-1:0]                wr_way_i,
    input  logic [tag_w(AW, SETS, WORDS)-1:0]     wr_tag_i,
    input  logic                                  wr_dirty_i,
    input  logic [WORDS*DW-1:0]                   wr_line_i
);

    localparam int TAGW = tag_w(AW, SETS, WORDS);
    localparam int LW   = WORDS * DW;

    logic [SETS-1:0] valid_q [WAYS];
    logic [SETS-1:0] dirty_q [WAYS];
    logic [TAGW-1:0] tag_q   [WAYS][SETS];
    logic [LW-1:0]   data_q  [WAYS][SETS];

    line_meta_t meta_rd [WAYS];

    always_comb begin
        for (int w = 0; w < WAYS; w++) begin
            meta_rd[w].valid = valid_q[w][idx_i];
            meta_rd[w].dirty = dirty_q[w][idx_i];
            meta_rd[w].tag   = TAG_MAX'(tag_q[w][idx_i]);
            hit_o[w]   = meta_rd[w].valid && (meta_rd[w].tag == TAG_MAX'(tag_i));
            valid_o[w] = meta_rd[w].valid;
            dirty_o[w] = meta_rd[w].dirty;
        end
    end

    assign sel_tag_o  = meta_rd[sel_way_i].tag[TAGW-1:0];
    assign sel_line_o = data_q[sel_way_i][idx_i];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int w = 0; w < WAYS; w++) begin
                valid_q[w] <= '0;
                dirty_q[w] <= '0;
            end
        end else if (wr_en_i) begin
            valid_q[wr_way_i][idx_i] <= 1'b1;
            dirty_q[wr_way_i][idx_i] <= wr_dirty_i;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            tag_q[wr_way_i][idx_i]  <= wr_tag_i;
            data_q[wr_way_i][idx_i] <= wr_line_i;
        end
    end

endmodule

// File: rtl/assoc_cache_ctrl.sv
// assoc_cache_ctrl
//   N-way set-associative, write-back, write-allocate cache controller.
//   Build option: define CACHE_LRU_EN for true-LRU replacement; otherwise a
//   per-set round-robin pointer advanced on each fill is used. Invalid ways
//   are always chosen first.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   cpu_valid/rw/addr/wdata  CPU request, held until cpu_ready
//   cpu_ready, cpu_rdata     one-cycle completion pulse and load data
//   mem_valid/rw/addr/wdata  line-wide memory request, held until mem_ready
//   mem_ready, mem_rdata     memory completion and fill line
module assoc_cache_ctrl
    import cache_def_pkg::*;
#(
    parameter int WAYS  = 2,
    parameter int SETS  = 8,
    parameter int WORDS = 4,
    parameter int DW    = 16,
    parameter int AW    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cpu_valid,
    input  logic                cpu_rw,
    input  logic [AW-1:0]       cpu_addr,
    input  logic [DW-1:0]       cpu_wdata,
    output logic                cpu_ready,
    output logic [DW-1:0]       cpu_rdata,
    output logic                mem_valid,
    output logic                mem_rw,
    output logic [AW-1:0]       mem_addr,
    output logic [WORDS*DW-1:0] mem_wdata,
    input  logic                mem_ready,
    input  logic [WORDS*DW-1:0] mem_rdata
);

    localparam int OFF  = off_w(WORDS);
    localparam int IDX  = idx_w(SETS);
    localparam int TAGW = tag_w(AW, SETS, WORDS);
    localparam int WAYW = way_w(WAYS);
    localparam int LW   = WORDS * DW;

    function automatic logic [LW-1:0] merge_word(input logic [LW-1:0] line,
                                                 input logic [OFF-1:0] off,
                                                 input logic [DW-1:0] word);
        logic [LW-1:0] res;
        res = line;
        res[off*DW +: DW] = word;
        return res;
    endfunction

    wire [OFF-1:0]  cpu_off = cpu_addr[OFF-1:0];
    wire [IDX-1:0]  cpu_idx = cpu_addr[OFF +: IDX];
    wire [TAGW-1:0] cpu_tag = cpu_addr[AW-1 -: TAGW];

    cache_state_t    state_q;
    logic            cpu_ready_q, mem_valid_q, mem_rw_q, vdirty_q;
    logic [DW-1:0]   cpu_rdata_q;
    logic [AW-1:0]   mem_addr_q;
    logic [LW-1:0]   mem_wdata_q;
    logic [WAYW-1:0] victim_q;

    logic [WAYS-1:0] hit_vec, valid_vec, dirty_vec;
    logic            hit;
    logic [WAYW-1:0] hit_way, pol_way, victim_way, sel_way, wr_way;
    logic [LW-1:0]   sel_line, wr_line;
    logic [TAGW-1:0] sel_tag;
    logic            wr_en, wr_dirty, fill_en, victim_dirty;

    // In IDLE the lookup reads the hitting way; afterwards the latched victim.
    assign sel_way = (state_q == IDLE) ? hit_way : victim_q;

    cache_set_array #(
        .WAYS(WAYS), .SETS(SETS), .WORDS(WORDS), .DW(DW), .AW(AW)
    ) u_array (
        .clk        (clk),
        .rst        (rst),
        .idx_i      (cpu_idx),
        .tag_i      (cpu_tag),
        .hit_o      (hit_vec),
        .valid_o    (valid_vec),
        .dirty_o    (dirty_vec),
        .sel_way_i  (sel_way),
        .sel_line_o (sel_line),
        .sel_tag_o  (sel_tag),
        .wr_en_i    (wr_en),
        .wr_way_i   (wr_way),
        .wr_tag_i   (cpu_tag),
        .wr_dirty_i (wr_dirty),
        .wr_line_i  (wr_line)
    );

    assign hit = |hit_vec;

    always_comb begin
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (hit_vec[w]) hit_way = WAYW'(w);
        end
    end

    // Lowest-index invalid way overrides the replacement policy.
    always_comb begin
        victim_way = pol_way;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_vec[w]) victim_way = WAYW'(w);
        end
    end

    assign victim_dirty = valid_vec[victim_way] & dirty_vec[victim_way];

    // Array writes: a store hit merges in IDLE; a fill (with a store miss
    // merged in) lands on the mem_ready edge of ALLOCATE.
    always_comb begin
        wr_en    = 1'b0;
        wr_way   = hit_way;
        wr_line  = merge_word(sel_line, cpu_off, cpu_wdata);
        wr_dirty = 1'b1;
        fill_en  = 1'b0;
        if (state_q == IDLE && cpu_valid && hit && cpu_rw) begin
            wr_en = 1'b1;
        end else if (state_q == ALLOCATE && mem_ready) begin
            wr_en    = 1'b1;
            fill_en  = 1'b1;
            wr_way   = victim_q;
            wr_dirty = cpu_rw;
            wr_line  = cpu_rw ? merge_word(mem_rdata, cpu_off, cpu_wdata) : mem_rdata;
        end
    end

`ifdef CACHE_LRU_EN
    logic [WAYW-1:0] age_q [SETS][WAYS];
    logic            lru_touch;
    logic [WAYW-1:0] lru_way;

    assign lru_touch = (state_q == IDLE && cpu_valid && hit) || fill_en;
    assign lru_way   = fill_en ? victim_q : hit_way;

    always_comb begin
        pol_way = '0;
        for (int w = 1; w < WAYS; w++) begin
            if (age_q[cpu_idx][w] > age_q[cpu_idx][pol_way]) pol_way = WAYW'(w);
        end
    end

    // Touched way becomes youngest; only ways younger than it age.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) age_q[s][w] <= WAYW'(w);
            end
        end else if (lru_touch) begin
            for (int w = 0; w < WAYS; w++) begin
                if (WAYW'(w) == lru_way)
                    age_q[cpu_idx][w] <= '0;
                else if (age_q[cpu_idx][w] < age_q[cpu_idx][lru_way])
                    age_q[cpu_idx][w] <= age_q[cpu_idx][w] + 1'b1;
            end
        end
    end
`else
    logic [WAYW-1:0] ptr_q [SETS];

    assign pol_way = ptr_q[cpu_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) ptr_q[s] <= '0;
        end else if (fill_en) begin
            ptr_q[cpu_idx] <= (ptr_q[cpu_idx] == WAYW'(WAYS - 1)) ? '0 : ptr_q[cpu_idx] + 1'b1;
        end
    end
`endif

    // The lookup result is registered on the IDLE edge so cpu_ready is a
    // flop that is high during COMPARE; a fill pre-loads the same pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cpu_ready_q <= 1'b0;
            cpu_rdata_q <= '0;
            mem_valid_q <= 1'b0;
            mem_rw_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            victim_q    <= '0;
            vdirty_q    <= 1'b0;
        end else begin
            cpu_ready_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cpu_valid) begin
                        state_q <= COMPARE;
                        if (hit) begin
                            cpu_ready_q <= 1'b1;
                            if (!cpu_rw) cpu_rdata_q <= sel_line[cpu_off*DW +: DW];
                        end else begin
                            victim_q <= victim_way;
                            vdirty_q <= victim_dirty;
                        end
                    end
                end
                COMPARE: begin
                    if (cpu_ready_q) begin
                        state_q <= IDLE;
                    end else begin
                        mem_valid_q <= 1'b1;
                        if (vdirty_q) begin
                            state_q     <= WRITE_BACK;
                            mem_rw_q    <= 1'b1;
                            mem_addr_q  <= {sel_tag, cpu_idx, {OFF{1'b0}}};
                            mem_wdata_q <= sel_line;
                        end else begin
                            state_q    <= ALLOCATE;
                            mem_rw_q   <= 1'b0;
                            mem_addr_q <= {cpu_tag, cpu_idx, {OFF{1'b0}}};
                        end
                    end
                end
                WRITE_BACK: begin
                    if (mem_ready) begin
                        state_q    <= ALLOCATE;
                        mem_rw_q   <= 1'b0;
                        mem_addr_q <= {cpu_tag, cpu_idx, {OFF{1'b0}}};
                    end
                end
                ALLOCATE: begin
                    if (mem_ready) begin
                        state_q     <= COMPARE;
                        mem_valid_q <= 1'b0;
                        cpu_ready_q <= 1'b1;
                        if (!cpu_rw) cpu_rdata_q <= mem_rdata[cpu_off*DW +: DW];
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cpu_ready = cpu_ready_q;
    assign cpu_rdata = cpu_rdata_q;
    assign mem_valid = mem_valid_q;
    assign mem_rw    = mem_rw_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_assoc_cache_ctrl.sv
// tb_assoc_cache_ctrl
//   Directed bench for assoc_cache_ctrl at default parameters. A line memory
//   model answers requests after a programmable number of wait cycles and
//   logs fills and write-backs. Honours CACHE_LRU_EN for replacement checks.
module tb_assoc_cache_ctrl;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int LW = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_valid, cpu_rw;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_ready;
    logic [DW-1:0] cpu_rdata;
    logic          mem_valid, mem_rw;
    logic [AW-1:0] mem_addr;
    logic [LW-1:0] mem_wdata;
    logic          mem_ready;
    logic [LW-1:0] mem_rdata;

    always #5 clk = ~clk;

    assoc_cache_ctrl #(.WAYS(2), .SETS(8), .WORDS(4), .DW(DW), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_valid (cpu_valid),
        .cpu_rw    (cpu_rw),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ready (cpu_ready),
        .cpu_rdata (cpu_rdata),
        .mem_valid (mem_valid),
        .mem_rw    (mem_rw),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- memory model ----------------
    int            mem_delay = 1;
    bit            force_ready = 1'b0;
    int            mcnt = 0;
    int            rd_cnt = 0;
    int            wb_cnt = 0;
    logic [AW-1:0] last_rd_addr = '0;
    logic [AW-1:0] last_wb_addr = '0;
    logic [LW-1:0] last_wb_data = '0;
    logic [LW-1:0] mem_store [logic [AW-1:0]];

    function automatic logic [LW-1:0] default_line(input logic [AW-1:0] a);
        return {a + 16'd3, a + 16'd2, a + 16'd1, a};
    endfunction

    initial begin
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_ready) begin
                mem_ready = 1'b0;
                mcnt = 0;
            end
            if (mem_valid) begin
                if (mcnt >= mem_delay) begin
                    mem_ready = 1'b1;
                    if (mem_rw) begin
                        mem_store[mem_addr] = mem_wdata;
                        wb_cnt++;
                        last_wb_addr = mem_addr;
                        last_wb_data = mem_wdata;
                    end else begin
                        mem_rdata = mem_store.exists(mem_addr) ? mem_store[mem_addr] : default_line(mem_addr);
                        rd_cnt++;
                        last_rd_addr = mem_addr;
                    end
                end else begin
                    mcnt++;
                end
            end else begin
                mcnt = 0;
                if (force_ready) begin
                    mem_ready = 1'b1;
                    mem_rdata = {4{16'hDEAD}};
                end
            end
        end
    end

    // ---------------- CPU driver ----------------
    // Called just after a negedge; returns one idle cycle after cpu_ready.
    task automatic access(input logic rw, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                          output logic [DW-1:0] rd, output int lat);
        lat = 0;
        rd = '0;
        cpu_valid = 1'b1;
        cpu_rw = rw;
        cpu_addr = addr;
        cpu_wdata = wd;
        do begin
            @(negedge clk);
            lat++;
        end while (!cpu_ready && lat < 200);
        if (cpu_ready) rd = cpu_rdata;
        else lat = -1;
        cpu_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cpu_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (cpu_ready !== 1'b0) begin errors++; $display("FAIL rst_cpu_ready got %0b expected 0", cpu_ready); end
        checks++; if (cpu_rdata !== 16'h0) begin errors++; $display("FAIL rst_cpu_rdata got %0h expected 0", cpu_rdata); end
        checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL rst_mem_valid got %0b expected 0", mem_valid); end
        checks++; if (mem_rw !== 1'b0) begin errors++; $display("FAIL rst_mem_rw got %0b expected 0", mem_rw); end
        checks++; if (mem_addr !== 16'h0) begin errors++; $display("FAIL rst_mem_addr got %0h expected 0", mem_addr); end
        checks++; if (mem_wdata !== 64'h0) begin errors++; $display("FAIL rst_mem_wdata got %0h expected 0", mem_wdata); end
    endtask

    task automatic test_read_miss();
        logic [DW-1:0] rd;
        int lat, rd0, wb0;
        mem_delay = 1;
        rd0 = rd_cnt;
        wb0 = wb_cnt;
        access(1'b0, 16'h0041, 16'h0, rd, lat);
        checks++; if (rd !== 16'h2222) begin errors++; $display("FAIL miss_rdata got %0h expected 2222", rd); end
        checks++; if (lat !== 4) begin errors++; $display("FAIL miss_latency got %0d expected 4", lat); end
        checks++; if (rd_cnt !== rd0 + 1) begin errors++; $display("FAIL miss_fill_count got %0d expected %0d", rd_cnt, rd0 + 1); end
        checks++; if (last_rd_addr !== 16'h0040) begin errors++; $display("FAIL miss_fill_addr got %0h expected 0040", last_rd_addr); end
        checks++; if (wb_cnt !== wb0) begin errors++; $display("FAIL miss_no_wb got %0d expected %0d", wb_cnt, wb0); end
    endtask

    task automatic test_write_hit();
        logic [DW-1:0] rd;
        int lat, rd0;
        rd0 = rd_cnt;
        access(1'b1, 16'h0042, 16'hBEEF, rd, lat);
        checks++; if (lat !== 1) begin errors++; $display("FAIL whit_latency got %0d expected 1", lat); end
        access(1'b0, 16'h0042, 16'h0, rd, lat);
        checks++; if (lat !== 1) begin errors++; $display("FAIL rhit_latency got %0d expected 1", lat); end
        checks++; if (rd !== 16'hBEEF) begin errors++; $display("FAIL rhit_rdata got %0h expected beef", rd); end
        access(1'b0, 16'h0041, 16'h0, rd, lat);
        checks++; if (rd !== 16'h2222) begin errors++; $display("FAIL rhit_neighbour got %0h expected 2222", rd); end
        checks++; if (rd_cnt !== rd0) begin errors++; $display("FAIL hit_no_fill got %0d expected %0d", rd_cnt, rd0); end
    endtask

    task automatic test_dirty_evict();
        logic [DW-1:0] rd;
        int lat, wb0;
        wb0 = wb_cnt;
        access(1'b0, 16'h0140, 16'h0, rd, lat);
        checks++; if (lat !== 4) begin errors++; $display("FAIL fill2_latency got %0d expected 4", lat); end
        checks++; if (rd !== 16'h0140) begin errors++; $display("FAIL fill2_rdata got %0h expected 0140", rd); end
        access(1'b0, 16'h0240, 16'h0, rd, lat);
        checks++; if (lat !== 6) begin errors++; $display("FAIL evict_latency got %0d expected 6", lat); end
        checks++; if (rd !== 16'h0240) begin errors++; $display("FAIL evict_rdata got %0h expected 0240", rd); end
        checks++; if (wb_cnt !== wb0 + 1) begin errors++; $display("FAIL evict_wb_count got %0d expected %0d", wb_cnt, wb0 + 1); end
        checks++; if (last_wb_addr !== 16'h0040) begin errors++; $display("FAIL evict_wb_addr got %0h expected 0040", last_wb_addr); end
        checks++; if (last_wb_data !== 64'h4444_BEEF_2222_1111) begin errors++; $display("FAIL evict_wb_data got %0h expected 4444beef22221111", last_wb_data); end
        checks++; if (last_rd_addr !== 16'h0240) begin errors++; $display("FAIL evict_fill_addr got %0h expected 0240", last_rd_addr); end
    endtask

    task automatic test_replacement();
        logic [DW-1:0] rd;
        int lat, wb0, exp_lat;
        do_reset();
        mem_delay = 1;
        wb0 = wb_cnt;
        access(1'b0, 16'h0040, 16'h0, rd, lat);
        checks++; if (lat !== 4) begin errors++; $display("FAIL repl_after_reset_miss got %0d expected 4", lat); end
        access(1'b0, 16'h0140, 16'h0, rd, lat);
        access(1'b0, 16'h0040, 16'h0, rd, lat);
        checks++; if (lat !== 1) begin errors++; $display("FAIL repl_rehit got %0d expected 1", lat); end
        access(1'b0, 16'h0240, 16'h0, rd, lat);
        checks++; if (lat !== 4) begin errors++; $display("FAIL repl_clean_evict got %0d expected 4", lat); end
        checks++; if (wb_cnt !== wb0) begin errors++; $display("FAIL repl_no_wb got %0d expected %0d", wb_cnt, wb0); end
`ifdef CACHE_LRU_EN
        exp_lat = 4;
`else
        exp_lat = 1;
`endif
        access(1'b0, 16'h0140, 16'h0, rd, lat);
        checks++; if (lat !== exp_lat) begin errors++; $display("FAIL repl_victim_choice got %0d expected %0d", lat, exp_lat); end
    endtask

    task automatic test_slow_mem();
        int lat, vcyc, unstable;
        mem_delay = 7;
        lat = 0; vcyc = 0; unstable = 0;
        cpu_valid = 1'b1; cpu_rw = 1'b0; cpu_addr = 16'h0305; cpu_wdata = '0;
        do begin
            @(negedge clk);
            lat++;
            if (mem_valid) begin
                vcyc++;
                if (mem_addr !== 16'h0304 || mem_rw !== 1'b0) unstable++;
            end
        end while (!cpu_ready && lat < 200);
        checks++; if (lat !== 10) begin errors++; $display("FAIL slow_latency got %0d expected 10", lat); end
        checks++; if (vcyc !== 8) begin errors++; $display("FAIL slow_valid_cycles got %0d expected 8", vcyc); end
        checks++; if (unstable !== 0) begin errors++; $display("FAIL slow_addr_stable got %0d expected 0", unstable); end
        checks++; if (cpu_rdata !== 16'h0305) begin errors++; $display("FAIL slow_rdata got %0h expected 0305", cpu_rdata); end
        cpu_valid = 1'b0;
        @(negedge clk);
        mem_delay = 1;
    endtask

    task automatic test_rst_in_wb();
        logic [DW-1:0] rd;
        int lat, wb0, n;
        mem_delay = 1;
        access(1'b1, 16'h0008, 16'h1234, rd, lat);
        checks++; if (lat !== 4) begin errors++; $display("FAIL wmiss_latency got %0d expected 4", lat); end
        access(1'b0, 16'h0108, 16'h0, rd, lat);
        mem_delay = 20;
        wb0 = wb_cnt;
        cpu_valid = 1'b1; cpu_rw = 1'b0; cpu_addr = 16'h0208; cpu_wdata = '0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mem_valid && n < 20);
        checks++; if (mem_rw !== 1'b1) begin errors++; $display("FAIL wb_rw got %0b expected 1", mem_rw); end
        checks++; if (mem_addr !== 16'h0008) begin errors++; $display("FAIL wb_addr got %0h expected 0008", mem_addr); end
        checks++; if (mem_wdata !== 64'h000B_000A_0009_1234) begin errors++; $display("FAIL wb_wdata got %0h expected 000b000a00091234", mem_wdata); end
        rst = 1'b1;
        cpu_valid = 1'b0;
        @(negedge clk);
        checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL rstwb_mem_valid got %0b expected 0", mem_valid); end
        checks++; if (mem_addr !== 16'h0) begin errors++; $display("FAIL rstwb_mem_addr got %0h expected 0", mem_addr); end
        checks++; if (mem_wdata !== 64'h0) begin errors++; $display("FAIL rstwb_mem_wdata got %0h expected 0", mem_wdata); end
        checks++; if (cpu_ready !== 1'b0) begin errors++; $display("FAIL rstwb_cpu_ready got %0b expected 0", cpu_ready); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (wb_cnt !== wb0) begin errors++; $display("FAIL rstwb_abandoned got %0d expected %0d", wb_cnt, wb0); end
        mem_delay = 1;
        access(1'b0, 16'h0040, 16'h0, rd, lat);
        checks++; if (lat !== 4) begin errors++; $display("FAIL rstwb_remiss got %0d expected 4", lat); end
        checks++; if (rd !== 16'h1111) begin errors++; $display("FAIL rstwb_rdata got %0h expected 1111", rd); end
    endtask

    task automatic test_spurious_ready();
        logic [DW-1:0] rd;
        int lat, rd0, bad;
        rd0 = rd_cnt;
        bad = 0;
        force_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (mem_valid !== 1'b0 || cpu_ready !== 1'b0) bad++;
        end
        force_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (bad !== 0) begin errors++; $display("FAIL spur_idle_quiet got %0d expected 0", bad); end
        access(1'b0, 16'h0040, 16'h0, rd, lat);
        checks++; if (lat !== 1) begin errors++; $display("FAIL spur_hit_latency got %0d expected 1", lat); end
        checks++; if (rd !== 16'h1111) begin errors++; $display("FAIL spur_rdata got %0h expected 1111", rd); end
        checks++; if (rd_cnt !== rd0) begin errors++; $display("FAIL spur_no_fill got %0d expected %0d", rd_cnt, rd0); end
    endtask

    initial begin
        rst = 1'b1;
        cpu_valid = 1'b0;
        cpu_rw = 1'b0;
        cpu_addr = '0;
        cpu_wdata = '0;
        mem_store[16'h0040] = 64'h4444_3333_2222_1111;
        @(negedge clk);
        test_reset();
        test_read_miss();
        test_write_hit();
        test_dirty_evict();
        test_replacement();
        test_slow_mem();
        test_rst_in_wb();
        test_spurious_ready();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/assoc_cache_ctrl.md
# assoc_cache_ctrl

Parametrised N-way set-associative, write-back, write-allocate cache controller with its tag/data storage. It sits between the CPU load/store port and the line-wide memory controller. It generalises the direct-mapped controller to configurable ways, sets, line size and word width. It adds victim selection across ways, with invalid ways preferred, and a level-held memory handshake.

## Interface
Parameters:
- WAYS, 2 — associativity; power of 2, range 1..8.
- SETS, 8 — number of sets; power of 2.
- WORDS, 4 — words per line; power of 2.
- DW, 16 — CPU word width in bits.
- AW, 16 — CPU word-address width.

Ports:
- clk  in  1 — clock; all state changes on rising edge.
- rst  in  1 — reset; synchronous, active-high.
- cpu_valid  in  1 — request present; held with addr/rw/wdata stable until cpu_ready.
- cpu_rw  in  1 — 1 = write, 0 = read.
- cpu_addr  in  AW — word address: {tag, index, offset}.
- cpu_wdata  in  DW — store data.
- cpu_ready  out  1 — one-cycle pulse; request complete.
- cpu_rdata  out  DW — load data; valid when cpu_ready=1.
- mem_valid  out  1 — memory request; held until mem_ready.
- mem_rw  out  1 — 1 = write-back line, 0 = fill line.
- mem_addr  out  AW — line address; offset bits forced to 0.
- mem_wdata  out  WORDS*DW — victim line.
- mem_ready  in  1 — memory done; sampled only while mem_valid=1.
- mem_rdata  in  WORDS*DW — fill line; valid when mem_ready=1.

## Operation
- Address split:
  - OFF = log2(WORDS), IDX = log2(SETS), TAGW = AW-IDX-OFF.
  - Word w of a line occupies bits [w*DW +: DW].
- States: IDLE, COMPARE, WRITE_BACK, ALLOCATE.
- IDLE: if cpu_valid, go to COMPARE.
- COMPARE, hit (any way valid with matching tag; at most one):
  - Assert cpu_ready.
  - Read: cpu_rdata = selected word.
  - Write: merge cpu_wdata into the word and set dirty.
  - Update the replacement state for that set; go to IDLE.
- COMPARE, miss:
  - Choose victim: lowest-index invalid way; otherwise the replacement-policy way.
  - Victim dirty: go to WRITE_BACK.
  - Victim clean or invalid: go to ALLOCATE.
  - Victim way index is latched.
- WRITE_BACK: mem_valid=1, mem_rw=1, mem_addr={victim tag, index, 0}, mem_wdata=victim line. On mem_ready, go to ALLOCATE.
- ALLOCATE: mem_valid=1, mem_rw=0, mem_addr={cpu tag, index, 0}. On mem_ready:
  - Write the fill line into the victim way.
  - Set tag to the new tag, valid=1, dirty=0.
  - Go to COMPARE, which then hits; a write miss merges its word there.
- Only one outstanding memory transaction at a time; no CPU request is accepted outside IDLE.
- Tag/valid/dirty/data arrays: synchronous write, combinational read.

## Timing
- Reset values: cpu_ready=0, cpu_rdata=0, mem_valid=0, mem_rw=0, mem_addr=0, mem_wdata=0, state=IDLE.
- Reset clears all valid and dirty bits and all replacement state; data and tag contents are don't-care.
- Hit latency: cpu_valid seen in IDLE at cycle N; cpu_ready at N+1.
- Clean miss: cpu_ready at N+1 + (ALLOCATE cycles including the mem_ready cycle) + 1.
- Dirty miss additionally includes the WRITE_BACK cycles.
- mem_ready is allowed in the first cycle of WRITE_BACK/ALLOCATE; the minimum dirty miss is 4 cycles to cpu_ready.
- mem_ready while mem_valid=0 is ignored.
- cpu_valid dropping before cpu_ready is a protocol violation; behaviour is undefined.
- rst in any state: next cycle is IDLE with outputs at reset values. An in-flight memory transaction is abandoned and mem_valid drops.
- WAYS=1 degenerates to direct-mapped, with victim = way 0.

## Configuration
- CACHE_LRU_EN defined:
  - True LRU: per-set age counter of log2(WAYS) bits per way.
  - On a hit or fill of way w, ways younger than w age by 1 and w is set to 0.
  - The victim is the way with maximum age.
  - Reset ages are way i = i.
- CACHE_LRU_EN undefined:
  - Per-set round-robin pointer of log2(WAYS) bits.
  - The victim is the pointer value; the pointer increments, with wrap-around, on each fill of that set only.
  - Hits do not update it.
- In both modes, invalid ways take precedence.

## Structure
- Shared package cache_def_pkg: state enum cache_state_t; line-metadata struct {valid, dirty, tag}; the address-split widths as localparam functions of the parameters.
- Sub-module cache_set_array: WAYS×SETS metadata + data storage, with per-way hit vector and victim read-out. The controller FSM and replacement logic stay in assoc_cache_ctrl.

## Test plan
All values use defaults (WAYS=2, SETS=8, WORDS=4, DW=16).
- Read miss after reset, addr 0x0041: mem read at 0x0040. Return line 0x4444_3333_2222_1111, mem_ready one cycle later. cpu_rdata=0x2222 and no write-back.
- Write hit, addr 0x0042 data 0xBEEF, then read 0x0042: both hit at N+1, read returns 0xBEEF.
- Fill 0x0040 (dirty) and 0x0140, then read 0x0240 (same set): write-back of the line at 0x0040 containing 0xBEEF, then fill at 0x0240.
- With CACHE_LRU_EN: access 0x0040, 0x0140, 0x0040, then 0x0240. The victim is the 0x0140 way. Without the macro, the victim is the way-0 line at 0x0040.
- mem_ready held low for 7 cycles in ALLOCATE: mem_valid/mem_addr stay stable throughout and cpu_ready does not pulse early.
- rst asserted during WRITE_BACK: the next cycle is IDLE with mem_valid=0. A re-read of 0x0040 misses (valid cleared).
